manchester_tx_param: RTL
========================

// Module: manchester_tx_param
// PURPOSE
//  Parametrised Manchester serializer; successor to the fixed 8-bit manchester_serial_top.
//  Accepts DATA_W-bit words on a valid/ready handshake and buffers them in a small FIFO.
//  Serialises each word as a Manchester bitstream with programmable bit rate, bit order and
//  encoding convention. Words stream back-to-back with no gap. Sits between the byte source and the line driver.
// PARAMETERS
//  DATA_W        8  word width, >=1
//  HALF_BIT_DIV  4  clk cycles per half-bit, >=1 (bit period = 2*HALF_BIT_DIV)
//  FIFO_DEPTH    4  input buffer depth in words, power of 2, >=2
//  MSB_FIRST     1  1: data_in[DATA_W-1] sent first; 0: data_in[0] first
//  IEEE_MODE     1  1: IEEE 802.3 (0=high->low, 1=low->high); 0: G.E. Thomas (inverted)
//  IDLE_LEVEL    0  serial_out level while nothing is being sent
// PORTS
//  clk         in   1       single clock, all logic on rising edge
//  rst         in   1       synchronous, active-high reset
//  valid       in   1       data_in holds a word to send
//  data_in     in   DATA_W  word to serialise
//  ready       out  1       block can accept a word this cycle
//  serial_out  out  1       Manchester line output, registered
//  tx_active   out  1       high while a word's half-bits are on serial_out
//  fifo_level  out  clog2(FIFO_DEPTH)+1  words buffered, not counting the word in the shifter
// BEHAVIOUR
//  Reset (rst=1 at an edge): serial_out=IDLE_LEVEL, tx_active=0, fifo_level=0, FIFO emptied.
//   ready=0 while rst is high; ready=1 on the first cycle after release. Reset mid-word aborts the word.
//  Handshake: word accepted on an edge with valid&&ready. ready = !full, from registered count only.
//   Full with a same-cycle pop: ready is still 0 (no push-through). data_in may change freely when not accepted.
//  FSM states:
//   IDLE  -> LOAD when FIFO is non-empty.
//   LOAD  pops the FIFO head into the shift register; bit_cnt=DATA_W-1 -> FIRST.
//   FIRST drives the first half-bit for HALF_BIT_DIV cycles -> SECOND.
//   SECOND drives the second half-bit for HALF_BIT_DIV cycles. Then:
//    bit_cnt!=0            -> FIRST with the next bit, bit_cnt-1.
//    bit_cnt==0, FIFO non-empty -> FIRST with the new word; the pop and shifter load happen
//     on the last SECOND cycle, so there is no idle gap.
//    bit_cnt==0, FIFO empty     -> IDLE.
//  Encoding, registered: for data bit b, first half = b ^ IEEE_MODE, second half = ~first half.
//  Latency: word accepted at edge N into an empty, idle block:
//   edge N+1 LOAD; serial_out shows the first half-bit from edge N+2 onward.
//  Word duration: 2*HALF_BIT_DIV*DATA_W cycles.
//  tx_active rises with the first half-bit and falls with the return to IDLE_LEVEL.
//  Divider: div_cnt counts 0..HALF_BIT_DIV-1. Its width is clog2(HALF_BIT_DIV)+1; no overflow possible.
//  fifo_level updates on the edge after a push/pop. Simultaneous push and pop leaves the count unchanged.
// STRUCTURE
//  manchester_defs.vh holds the FSM state localparams (IDLE/LOAD/FIRST/SECOND),
//   the encode function and the clog2 function.
//  Sub-module sync_fifo (DATA_W, FIFO_DEPTH): sync reset, registered count, no fall-through,
//   wr_en/rd_en/full/empty.
//  The top contains the FSM, the divider, the bit counter and the shift register.
// TESTING
//  T1 defaults, one word 8'hCC: serial_out half-bits 01 01 10 10 01 01 10 10.
//   Each half-bit lasts 4 cycles; starts 2 cycles after acceptance; 64 cycles total; then idle 0.
//  T2 words 8'hCC,8'h55,8'hF0,8'h0F held valid: all accepted.
//   Continuous 256-cycle stream, no idle half-bit between words; tx_active high throughout.
//  T3 FIFO_DEPTH=4, valid held with 6 words: ready drops after 4 buffered.
//   Words are accepted as the shifter pops; fifo_level never exceeds 4; order preserved.
//  T4 IEEE_MODE=0, MSB_FIRST=0, HALF_BIT_DIV=1, DATA_W=4, word 4'b0001:
//   half-bits 10 01 01 01, 8 cycles total.
//  T5 rst asserted mid-word at cycle 20 of 8'hA5:
//   next edge serial_out=IDLE_LEVEL, tx_active=0, fifo_level=0.
//   A fresh 8'h3C afterwards is sent intact.
//  T6 random words/valid gaps over 1000 words, a decoder model checks data, order and timing;
//   no word is lost or duplicated.

Source files
------------

// File: rtl/manchester_tx_param_pkg.sv
// rtl/manchester_tx_param_pkg.sv - shared FSM states and helper functions for the Manchester serializer
//
// Purpose: FSM state encoding, the half-bit encode function and a constant
// clog2 used for port and counter widths across the serializer files.
package manchester_tx_param_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FIRST,
    SECOND
  } state_t;

  // Number of address bits needed for 'value' entries (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  // Level of the first half-bit; the second half is always its inverse.
  function automatic logic encode(input logic data_bit, input logic ieee_mode);
    return data_bit ^ ieee_mode;
  endfunction

endpackage

// File: rtl/manchester_tx_param_sync_fifo.sv
// rtl/manchester_tx_param_sync_fifo.sv - synchronous word FIFO feeding the Manchester shifter
//
// Purpose: DEPTH-entry FIFO with registered occupancy count and no fall-through
// (a written word is visible on rd_data only from the cycle after the write).
// Ports:
//   clk, rst         clock, synchronous active-high reset (empties the FIFO)
//   wr_en, wr_data   push request and word (ignored when full)
//   rd_en, rd_data   pop request (ignored when empty) and current head word
//   full, empty      derived from the registered count
//   count            words currently stored
module sync_fifo
  import manchester_tx_param_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [clog2(DEPTH):0]    count
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/manchester_tx_param.sv
// rtl/manchester_tx_param.sv - parametrised buffered Manchester serializer
//
// Purpose: accepts DATA_W-bit words on valid/ready, buffers them in sync_fifo and
// sends each as 2*DATA_W half-bits of HALF_BIT_DIV cycles, words back-to-back.
// Ports:
//   clk, rst     clock, synchronous active-high reset (aborts the current word)
//   valid        data_in holds a word to send
//   data_in      word to serialise
//   ready        a word can be accepted this cycle (low while full or in reset)
//   serial_out   registered Manchester line output, IDLE_LEVEL when not sending
//   tx_active    high while a word's half-bits are on serial_out
//   fifo_level   words buffered, excluding the word in the shifter
module manchester_tx_param
  import manchester_tx_param_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int HALF_BIT_DIV = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int MSB_FIRST    = 1,
  parameter int IEEE_MODE    = 1,
  parameter int IDLE_LEVEL   = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid,
  input  logic [DATA_W-1:0]           data_in,
  output logic                        ready,
  output logic                        serial_out,
  output logic                        tx_active,
  output logic [clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int DW = clog2(HALF_BIT_DIV) + 1;
  localparam int BW = clog2(DATA_W) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(HALF_BIT_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic IEEE     = (IEEE_MODE != 0);
  localparam logic IDLE_BIT = (IDLE_LEVEL != 0);

  state_t            state;
  state_t            next_state;
  logic [DW-1:0]     div_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_next;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic              half_done;
  logic              last_bit;
  logic              pop;
  logic              shift;
  logic              finish;
  logic              next_bit;

  // ready comes from the registered count only, so a pop in the same cycle
  // never lets a word through a full FIFO.
  assign ready = !fifo_full && !rst;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (valid && ready),
    .wr_data (data_in),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_level)
  );

  assign half_done = (div_cnt == DIV_LAST);
  assign last_bit  = (bit_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (!fifo_empty) next_state = LOAD;
      LOAD:   next_state = FIRST;
      FIRST:  if (half_done) next_state = SECOND;
      SECOND: if (half_done) begin
        if (!last_bit || !fifo_empty) next_state = FIRST;
        else                          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The chained pop on the last SECOND cycle is what removes the inter-word gap.
  always_comb begin
    pop    = 1'b0;
    shift  = 1'b0;
    finish = 1'b0;
    case (state)
      LOAD: pop = 1'b1;
      SECOND: if (half_done) begin
        if (!last_bit)        shift  = 1'b1;
        else if (!fifo_empty) pop    = 1'b1;
        else                  finish = 1'b1;
      end
      default: ;
    endcase
  end

  // The bit to encode is taken from the shifter's next value so serial_out
  // changes on the same edge as the state.
  always_comb begin
    shreg_next = shreg;
    if (pop)             shreg_next = fifo_rd_data;
    else if (shift)      shreg_next = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
    next_bit = (MSB_FIRST != 0) ? shreg_next[DATA_W-1] : shreg_next[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      serial_out <= IDLE_BIT;
      tx_active  <= 1'b0;
    end else begin
      shreg <= shreg_next;
      if (state == FIRST || state == SECOND) div_cnt <= half_done ? '0 : div_cnt + 1'b1;
      else                                   div_cnt <= '0;
      if (pop)        bit_cnt <= BIT_LAST;
      else if (shift) bit_cnt <= bit_cnt - 1'b1;
      if (pop || shift) begin
        serial_out <= encode(next_bit, IEEE);
        tx_active  <= 1'b1;
      end else if (finish) begin
        serial_out <= IDLE_BIT;
        tx_active  <= 1'b0;
      end else if (state == FIRST && half_done) begin
        serial_out <= ~serial_out;
      end
    end
  end

endmodule
